// File: rtl/branch_resolve.sv
// ID-stage branch resolution: evaluates the condition code against the registered flags, stalls
// one cycle on a pending flag write, and issues a registered one-cycle redirect/flush when taken.
module branch_resolve #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       br_cond,
  input  logic [8:0]       br_offset,
  input  logic [15:0]      pc_next,
  input  logic [15:0]      rs_data,
  input  logic [2:0]       flags,
  input  logic             ex_flag_wen,
  output logic             stall,
  output logic             redirect,
  output logic [15:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StRedir} state_e;

  state_e      state_q, state_d;
  logic        flag_z, flag_v, flag_n;
  logic        cond_true;
  logic        hazard;
  logic        eval;
  logic        taken;
  logic        stall_raw;
  logic [15:0] offset_ext;
  logic [15:0] target;
  logic [15:0] redirect_pc_q;
  logic [CNT_W-1:0] taken_cnt_q;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  // Word offset scaled to bytes; the adder wraps at 16 bits.
  assign offset_ext = {{6{br_offset[8]}}, br_offset, 1'b0};
  assign target     = br_reg ? rs_data : (pc_next + offset_ext);

  assign hazard = br_valid & ex_flag_wen & (br_cond != 3'b111);

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    eval      = 1'b0;
    case (state_q)
      StIdle: begin
        if (hazard) begin
          stall_raw = 1'b1;
          state_d   = StWait;
        end else if (br_valid) begin
          eval = 1'b1;
        end
      end
      // EX holds a bubble here, so ex_flag_wen cannot matter.
      StWait: begin
        state_d = StIdle;
        eval    = br_valid;
      end
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (eval && cond_true) begin
      state_d = StRedir;
    end
  end

  assign taken = eval & cond_true & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      redirect_pc_q <= 16'h0000;
      taken_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (taken) begin
        redirect_pc_q <= target;
        if (taken_cnt_q != {CNT_W{1'b1}}) begin
          taken_cnt_q <= taken_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign stall       = stall_raw & ~rst;
  assign redirect    = (state_q == StRedir) & ~rst;
  assign flush       = (state_q == StRedir) & ~rst;
  assign redirect_pc = redirect_pc_q;
  assign taken_cnt   = taken_cnt_q;

endmodule
